// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshaking on both sides.
// S1 only captures operands; S2 computes the result and {V,C,N,Z} flags and holds them until consumed.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_in,
    output logic             in_ready,
    input  logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             en_out,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_SUB = 3'd1;
    localparam logic [2:0] FUNC_AND = 3'd2;
    localparam logic [2:0] FUNC_OR  = 3'd3;
    localparam logic [2:0] FUNC_XOR = 3'd4;
    localparam logic [2:0] FUNC_SLL = 3'd5;
    localparam logic [2:0] FUNC_SRL = 3'd6;
    localparam logic [2:0] FUNC_SRA = 3'd7;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_func_reg;

    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_out_reg;
    logic [3:0]       s2_flags_reg;

    logic             s1_adv;
    logic             s2_adv;

    // S2 frees up when empty or being drained; S1 can move whenever S2 can take it.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    assign en_out  = s2_valid_reg;
    assign alu_out = s2_out_reg;
    assign flags   = s2_flags_reg;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   sh;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] res_next;
    logic             v_next;
    logic             c_next;
    logic [3:0]       flags_next;

    assign sum_ext  = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
    assign diff_ext = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
    assign sh       = s1_b_reg[SHW-1:0];
    assign add_ovf  = (s1_a_reg[WIDTH-1] == s1_b_reg[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != s1_a_reg[WIDTH-1]);
    assign sub_ovf  = (s1_a_reg[WIDTH-1] != s1_b_reg[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != s1_a_reg[WIDTH-1]);

    always_comb begin
        res_next = '0;
        v_next   = 1'b0;
        c_next   = 1'b0;
        case (s1_func_reg)
            FUNC_ADD: begin
                res_next = sum_ext[WIDTH-1:0];
                c_next   = sum_ext[WIDTH];
                v_next   = add_ovf;
            end
            FUNC_SUB: begin
                res_next = diff_ext[WIDTH-1:0];
                c_next   = diff_ext[WIDTH];
                v_next   = sub_ovf;
            end
            FUNC_AND: res_next = s1_a_reg & s1_b_reg;
            FUNC_OR:  res_next = s1_a_reg | s1_b_reg;
            FUNC_XOR: res_next = s1_a_reg ^ s1_b_reg;
            FUNC_SLL: res_next = s1_a_reg << sh;
            FUNC_SRL: res_next = s1_a_reg >> sh;
            FUNC_SRA: res_next = $signed(s1_a_reg) >>> sh;
            default:  res_next = '0;
        endcase
        // On overflow the true result has the sign of operand A for both ADD and SUB.
        if (SAT && v_next) begin
            res_next = s1_a_reg[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        flags_next = {v_next, c_next, res_next[WIDTH-1], (res_next == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_func_reg  <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= en_in;
            if (en_in) begin
                s1_a_reg    <= alu_a;
                s1_b_reg    <= alu_b;
                s1_func_reg <= alu_func;
            end
        end
    end

    // Result registers only update when S2 advances, so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_out_reg   <= '0;
            s2_flags_reg <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_out_reg   <= res_next;
                s2_flags_reg <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: three instances (16-bit wrap, 16-bit saturating, 32-bit wrap).
// Stimulus pushes hand-computed expectations; per-instance monitors pop and compare on each transfer.
module tb_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [3:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        en_in0, in_ready0, en_out0, out_ready0;
    logic [2:0]  func0;
    logic [15:0] a0, b0, out0;
    logic [3:0]  flags0;

    logic        en_in1, in_ready1, en_out1, out_ready1;
    logic [2:0]  func1;
    logic [15:0] a1, b1, out1;
    logic [3:0]  flags1;

    logic        en_in2, in_ready2, en_out2, out_ready2;
    logic [2:0]  func2;
    logic [31:0] a2, b2, out2;
    logic [3:0]  flags2;

    alu_pipe #(.WIDTH(16), .SAT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_in(en_in0), .in_ready(in_ready0), .alu_func(func0),
        .alu_a(a0), .alu_b(b0), .en_out(en_out0), .out_ready(out_ready0), .alu_out(out0), .flags(flags0)
    );
    alu_pipe #(.WIDTH(16), .SAT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_in(en_in1), .in_ready(in_ready1), .alu_func(func1),
        .alu_a(a1), .alu_b(b1), .en_out(en_out1), .out_ready(out_ready1), .alu_out(out1), .flags(flags1)
    );
    alu_pipe #(.WIDTH(32), .SAT(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en_in(en_in2), .in_ready(in_ready2), .alu_func(func2),
        .alu_a(a2), .alu_b(b2), .en_out(en_out2), .out_ready(out_ready2), .alu_out(out2), .flags(flags2)
    );

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic pop_check(int d, logic [31:0] got, logic [3:0] gf);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d spurious result: got %h, expected no result", d, got);
        end else begin
            case (d)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("dut%0d %s result", d, e.name), got, e.data);
            check($sformatf("dut%0d %s flags", d, e.name), {28'b0, gf}, {28'b0, e.flg});
            if (e.lat) check($sformatf("dut%0d %s latency", d, e.name), cyc - e.acc, 2);
        end
    endtask

    always @(negedge clk) if (rst_n && en_out0 && out_ready0) pop_check(0, {16'b0, out0}, flags0);
    always @(negedge clk) if (rst_n && en_out1 && out_ready1) pop_check(1, {16'b0, out1}, flags1);
    always @(negedge clk) if (rst_n && en_out2 && out_ready2) pop_check(2, out2, flags2);

    // Presents one op to instance d, waits (bounded) for acceptance, then records the expectation.
    task automatic send(int d, string name, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] ed, logic [3:0] ef, bit lat);
        bit   acc = 1'b0;
        int   tries = 0;
        int   acc_cyc = 0;
        exp_t e;
        case (d)
            0:       begin en_in0 = 1'b1; func0 = f; a0 = a[15:0]; b0 = b[15:0]; end
            1:       begin en_in1 = 1'b1; func1 = f; a1 = a[15:0]; b1 = b[15:0]; end
            default: begin en_in2 = 1'b1; func2 = f; a2 = a;       b2 = b;       end
        endcase
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc_cyc = cyc;
            case (d)
                0:       acc = in_ready0;
                1:       acc = in_ready1;
                default: acc = in_ready2;
            endcase
            @(posedge clk);
            #1;
            tries++;
        end
        en_in0 = 1'b0;
        en_in1 = 1'b0;
        en_in2 = 1'b0;
        if (!acc) begin
            check($sformatf("dut%0d %s accept timeout", d, name), {31'b0, acc}, 1);
        end else begin
            e = '{name, ed, ef, acc_cyc, lat};
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        check("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);
    endtask

    logic [2:0]  bp_f[4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    logic [15:0] bp_a[4] = '{16'h0001, 16'h0009, 16'h00F0, 16'h00FF};
    logic [15:0] bp_b[4] = '{16'h0002, 16'h0004, 16'h000F, 16'h000F};
    logic [15:0] bp_e[4] = '{16'h0003, 16'h0005, 16'h00FF, 16'h00F0};

    initial begin
        bit acc;
        int nacc;
        rst_n = 1'b0;
        en_in0 = 1'b0; en_in1 = 1'b0; en_in2 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
        func0 = '0; func1 = '0; func2 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset en_out", {31'b0, en_out0}, 0);
        check("reset alu_out", {16'b0, out0}, 0);
        check("reset flags", {28'b0, flags0}, 0);
        check("reset in_ready", {31'b0, in_ready0}, 1);
        check("reset alu_out w32", out2, 0);
        @(posedge clk);
        #1;

        // Basic functions, back-to-back, latency checked.
        send(0, "ADD", 3'd0, 32'h0041, 32'h0021, 32'h0062, 4'b0000, 1'b1);
        send(0, "SUB", 3'd1, 32'h0041, 32'h0021, 32'h0020, 4'b0000, 1'b1);
        send(0, "AND", 3'd2, 32'h0041, 32'h0021, 32'h0001, 4'b0000, 1'b1);
        send(0, "OR",  3'd3, 32'h0041, 32'h0021, 32'h0061, 4'b0000, 1'b1);
        send(0, "XOR", 3'd4, 32'h0041, 32'h0021, 32'h0060, 4'b0000, 1'b1);
        send(0, "SLL", 3'd5, 32'h0041, 32'h0021, 32'h0082, 4'b0000, 1'b1);
        send(0, "SRL", 3'd6, 32'h0041, 32'h0021, 32'h0020, 4'b0000, 1'b1);
        send(0, "SRA", 3'd7, 32'h8041, 32'h0001, 32'hC020, 4'b0010, 1'b1);
        // Flags, wrapping arithmetic ({V,C,N,Z}).
        send(0, "ADD carry", 3'd0, 32'hFFFF, 32'h0001, 32'h0000, 4'b0101, 1'b1);
        send(0, "ADD ovf",   3'd0, 32'h7FFF, 32'h0001, 32'h8000, 4'b1010, 1'b1);
        send(0, "SUB borrow",3'd1, 32'h0001, 32'h0002, 32'hFFFF, 4'b0110, 1'b1);
        // Saturating instance.
        send(1, "SAT ADD pos", 3'd0, 32'h7FFF, 32'h0001, 32'h7FFF, 4'b1000, 1'b1);
        send(1, "SAT SUB neg", 3'd1, 32'h8000, 32'h0001, 32'h8000, 4'b1010, 1'b1);
        send(1, "SAT ADD ok",  3'd0, 32'h0041, 32'h0021, 32'h0062, 4'b0000, 1'b1);
        // 32-bit instance: upper shift-amount bits ignored.
        send(2, "W32 SLL", 3'd5, 32'h00000001, 32'hFFFFFFE1, 32'h00000002, 4'b0000, 1'b1);
        send(2, "W32 ADD", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101, 1'b1);
        drain();

        // Back-pressure: four ops presented with the consumer stalled.
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        nacc = 0;
        for (int c = 0; c < 4; c++) begin
            en_in0 = 1'b1; func0 = bp_f[nacc]; a0 = bp_a[nacc]; b0 = bp_b[nacc];
            @(negedge clk);
            acc = in_ready0;
            if (c >= 2) begin
                check("stall en_out", {31'b0, en_out0}, 1);
                check("stall alu_out", {16'b0, out0}, 32'h0003);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                q0.push_back('{$sformatf("bp op%0d", nacc), {16'b0, bp_e[nacc]}, 4'b0000, 0, 1'b0});
                nacc++;
            end
        end
        en_in0 = 1'b0;
        check("bp accepted while stalled", nacc, 2);
        @(negedge clk);
        check("bp in_ready low", {31'b0, in_ready0}, 0);
        check("bp alu_out held", {16'b0, out0}, 32'h0003);
        @(posedge clk);
        #1;
        out_ready0 = 1'b1;
        #1;
        check("bp in_ready on release", {31'b0, in_ready0}, 1);
        send(0, "bp op2", bp_f[2], {16'b0, bp_a[2]}, {16'b0, bp_b[2]}, {16'b0, bp_e[2]}, 4'b0000, 1'b0);
        send(0, "bp op3", bp_f[3], {16'b0, bp_a[3]}, {16'b0, bp_b[3]}, {16'b0, bp_e[3]}, 4'b0000, 1'b0);
        drain();

        // Reset with two ops in flight: both must vanish.
        @(posedge clk);
        #1;
        en_in0 = 1'b1; func0 = 3'd1; a0 = 16'h0001; b0 = 16'h0002;
        @(posedge clk);
        #1;
        func0 = 3'd0; a0 = 16'h0005; b0 = 16'h0005;
        @(posedge clk);
        #1;
        en_in0 = 1'b0;
        check("pre-reset en_out", {31'b0, en_out0}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-reset en_out", {31'b0, en_out0}, 0);
        check("mid-reset alu_out", {16'b0, out0}, 0);
        check("mid-reset flags", {28'b0, flags0}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post-reset in_ready", {31'b0, in_ready0}, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-reset no stale result", {31'b0, en_out0}, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
